// File: rtl/fpu_exponent_aligner_if.sv
// Operand/result handshake bundle for the FP add/sub pre-adder alignment unit.
// Upstream plus the adder side use the master modport; the aligner uses the slave modport.
interface fpu_exponent_aligner_if #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [Mantissa_Size:0]   a_mantissa;
  logic [Exponent_Size-1:0] a_exponent;
  logic [Mantissa_Size:0]   b_mantissa;
  logic [Exponent_Size-1:0] b_exponent;
  logic                     out_valid;
  logic                     out_ready;
  logic [Mantissa_Size:0]   large_mantissa;
  logic [Mantissa_Size+3:0] small_mantissa;
  logic [Exponent_Size-1:0] common_exponent;
  logic                     swapped;

  modport master (
    output in_valid, a_mantissa, a_exponent, b_mantissa, b_exponent, out_ready,
    input  in_ready, out_valid, large_mantissa, small_mantissa, common_exponent, swapped
  );

  modport slave (
    input  in_valid, a_mantissa, a_exponent, b_mantissa, b_exponent, out_ready,
    output in_ready, out_valid, large_mantissa, small_mantissa, common_exponent, swapped
  );
endinterface

// File: rtl/fpu_exponent_aligner.sv
// Multi-cycle exponent aligner: picks the larger-exponent operand and right-shifts the
// other mantissa one bit per cycle, keeping guard/round/sticky, until exponents match.
module fpu_exponent_aligner #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic clk,
  input  logic rst,
  fpu_exponent_aligner_if.slave bus
);
  localparam int W = Mantissa_Size + 4;
  localparam logic [Exponent_Size-1:0] W_CAP = Exponent_Size'(W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                   r_state;
  logic [Exponent_Size-1:0] r_count;
  logic [Mantissa_Size:0]   r_large_mantissa;
  logic [W-1:0]             r_small;
  logic [Exponent_Size-1:0] r_common_exponent;
  logic                     r_swapped;

  logic                     w_a_ge_b;
  logic [Exponent_Size-1:0] w_diff;
  logic [Exponent_Size-1:0] w_load_count;

  always_comb begin
    w_a_ge_b     = (bus.a_exponent >= bus.b_exponent);
    w_diff       = w_a_ge_b ? (bus.a_exponent - bus.b_exponent)
                            : (bus.b_exponent - bus.a_exponent);
    // Beyond W shifts every original bit is already folded into sticky.
    w_load_count = (w_diff > W_CAP) ? W_CAP : w_diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_count           <= '0;
      r_large_mantissa  <= '0;
      r_small           <= '0;
      r_common_exponent <= '0;
      r_swapped         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_a_ge_b) begin
              r_large_mantissa  <= bus.a_mantissa;
              r_small           <= {bus.b_mantissa, 3'b000};
              r_common_exponent <= bus.a_exponent;
              r_swapped         <= 1'b0;
            end else begin
              r_large_mantissa  <= bus.b_mantissa;
              r_small           <= {bus.a_mantissa, 3'b000};
              r_common_exponent <= bus.b_exponent;
              r_swapped         <= 1'b1;
            end
            r_count <= w_load_count;
            r_state <= (w_load_count == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_small <= {1'b0, r_small[W-1:2], r_small[1] | r_small[0]};
          r_count <= r_count - 1'b1;
          if (r_count == Exponent_Size'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (r_state == S_IDLE);
  assign bus.out_valid       = (r_state == S_DONE);
  assign bus.large_mantissa  = r_large_mantissa;
  assign bus.small_mantissa  = r_small;
  assign bus.common_exponent = r_common_exponent;
  assign bus.swapped         = r_swapped;
endmodule

// File: tb/tb_fpu_exponent_aligner.sv
// Directed-vector bench for fpu_exponent_aligner with hand-computed expected results.
module tb_fpu_exponent_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fpu_exponent_aligner_if #(.Mantissa_Size(23), .Exponent_Size(8)) bus_if ();

  fpu_exponent_aligner #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".in_ready"},  32'(bus_if.in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, ".large"},     32'(bus_if.large_mantissa), 32'h0);
    chk({tag, ".small"},     32'(bus_if.small_mantissa), 32'h0);
    chk({tag, ".cexp"},      32'(bus_if.common_exponent), 32'h0);
    chk({tag, ".swapped"},   32'(bus_if.swapped), 32'd0);
  endtask

  // Present a pair at a negedge; the next posedge accepts it. Leaves the DUT in DONE.
  task automatic run_pair(input string tag,
                          input logic [23:0] am, input logic [7:0] ae,
                          input logic [23:0] bm, input logic [7:0] be,
                          input logic [31:0] exp_large, input logic [31:0] exp_small,
                          input logic [31:0] exp_cexp, input logic exp_swap,
                          input int unsigned exp_lat);
    int unsigned lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid   = 1'b1;
    bus_if.a_mantissa = am;
    bus_if.a_exponent = ae;
    bus_if.b_mantissa = bm;
    bus_if.b_exponent = be;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".large"},   32'(bus_if.large_mantissa), exp_large);
    chk({tag, ".small"},   32'(bus_if.small_mantissa), exp_small);
    chk({tag, ".cexp"},    32'(bus_if.common_exponent), exp_cexp);
    chk({tag, ".swapped"}, 32'(bus_if.swapped), 32'(exp_swap));
  endtask

  task automatic drain(input string tag);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk({tag, ".drain_in_ready"},  32'(bus_if.in_ready), 32'd1);
    chk({tag, ".drain_out_valid"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    bus_if.in_valid   = 1'b0;
    bus_if.out_ready  = 1'b0;
    bus_if.a_mantissa = '0;
    bus_if.a_exponent = '0;
    bus_if.b_mantissa = '0;
    bus_if.b_exponent = '0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_pair("basic", 24'hC00000, 8'h80, 24'h800000, 8'h7E,
             32'hC00000, 32'h1000000, 32'h80, 1'b0, 3);
    drain("basic");

    run_pair("swap", 24'h800001, 8'h7F, 24'hFFFFFF, 8'h81,
             32'hFFFFFF, 32'h1000002, 32'h81, 1'b1, 3);
    drain("swap");

    run_pair("sticky", 24'h800000, 8'h85, 24'hFFFFFF, 8'h80,
             32'h800000, 32'h3FFFFF, 32'h85, 1'b0, 6);
    drain("sticky");

    run_pair("saturate", 24'hFFFFFF, 8'hFF, 24'h800001, 8'h00,
             32'hFFFFFF, 32'h0000001, 32'hFF, 1'b0, 28);
    drain("saturate");

    run_pair("equal", 24'h900000, 8'h40, 24'hA00000, 8'h40,
             32'h900000, 32'h5000000, 32'h40, 1'b0, 1);

    // Backpressure: stay in DONE while a new pair is waved at the input.
    bus_if.in_valid   = 1'b1;
    bus_if.a_mantissa = 24'h123456;
    bus_if.a_exponent = 8'h10;
    bus_if.b_mantissa = 24'hABCDEF;
    bus_if.b_exponent = 8'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.out_valid", 32'(bus_if.out_valid), 32'd1);
      chk("bp.in_ready",  32'(bus_if.in_ready), 32'd0);
      chk("bp.small",     32'(bus_if.small_mantissa), 32'h5000000);
      chk("bp.cexp",      32'(bus_if.common_exponent), 32'h40);
      chk("bp.large",     32'(bus_if.large_mantissa), 32'h900000);
    end
    bus_if.in_valid = 1'b0;
    drain("bp");

    // Reset mid-shift: d = 20, abort after 10 shifts.
    @(negedge clk);
    bus_if.in_valid   = 1'b1;
    bus_if.a_mantissa = 24'h800000;
    bus_if.a_exponent = 8'h94;
    bus_if.b_mantissa = 24'hFFFFFF;
    bus_if.b_exponent = 8'h80;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid.busy", 32'(bus_if.in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rstmid.no_result", 32'(bus_if.out_valid), 32'd0);

    run_pair("after_rst", 24'hC00000, 8'h80, 24'h800000, 8'h7E,
             32'hC00000, 32'h1000000, 32'h80, 1'b0, 3);
    drain("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fpu_exponent_aligner.md
# fpu_exponent_aligner

Multi-cycle pre-adder alignment unit: the inverse operation of normalization. It accepts two unpacked operands (hidden bit included) and picks the one with the larger exponent. It shifts the smaller operand's mantissa right, one bit per cycle, until both exponents match, and keeps guard, round and sticky bits. It sits between operand unpacking and the mantissa adder of the FP add/sub path; its outputs feed the adder and then `fpu_normalizer`.

## Interface
- `Mantissa_Size`, default 23: stored mantissa bits. Unpacked mantissas are `Mantissa_Size+1` bits wide.
- `Exponent_Size`, default 8: exponent bits. Requires `Mantissa_Size+4 < 2**Exponent_Size`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  aligner idle; accepts the pair this cycle.
- `a_mantissa`  in  Mantissa_Size+1  operand A, hidden bit at MSB.
- `a_exponent`  in  Exponent_Size  operand A biased exponent.
- `b_mantissa`  in  Mantissa_Size+1  operand B.
- `b_exponent`  in  Exponent_Size  operand B.
- `out_valid`  out  1  aligned result available.
- `out_ready`  in  1  consumer takes the result.
- `large_mantissa`  out  Mantissa_Size+1  mantissa of the larger-exponent operand, unshifted.
- `small_mantissa`  out  Mantissa_Size+4  shifted mantissa `{mant, G, R, S}`.
- `common_exponent`  out  Exponent_Size  larger exponent.
- `swapped`  out  1  1 when B was the larger operand.

## Operation
- `W = Mantissa_Size+4` is the internal small-operand register width.
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE), decoded combinationally from registered state. `out_valid` = (state == DONE).
- IDLE, on `in_valid && in_ready`:
  - If `a_exponent >= b_exponent`: large = A, small = B, `swapped` = 0.
  - Otherwise: large = B, small = A, `swapped` = 1.
  - Ties do not swap. Mantissas are not compared.
  - Load small register = `{small_mant, 3'b000}`.
  - Load `common_exponent` = larger exponent.
  - Load counter = min(large_exp − small_exp, W). The subtraction is unsigned and cannot underflow after the compare.
  - Next state: DONE if the counter is 0, else SHIFT.
- SHIFT, each cycle:
  - small register ← `{1'b0, s[W-1:2], s[1] | s[0]}`. Bit 0 is sticky and accumulates every bit shifted past it.
  - Counter decrements.
  - When the counter reaches 1 (last shift), next state is DONE.
- The cap at W is exact: after W shifts every original bit has folded into sticky, so further shifts cannot change the value.
- DONE:
  - Outputs hold stable while `out_ready` = 0.
  - On `out_ready` = 1, go to IDLE.
  - `in_valid` is ignored outside IDLE. Upstream must hold its operands until `in_ready`.
- Zero or denormal operands get no special handling. Alignment is driven by the exponent fields only.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, so `in_ready` = 1 and `out_valid` = 0.
  - `large_mantissa`, `small_mantissa`, `common_exponent`, `swapped` = 0.
  - Counter = 0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No result is ever presented for an aborted pair.
- Latency: pair accepted at edge k → `out_valid` high after edge k+1+min(d, W), where d = exponent difference.
  - d = 0 gives 1 cycle.
  - d ≥ 27 (default parameters) gives 28 cycles.
- Throughput: one pair per (latency + 1) cycles when `out_ready` is held high, because of the DONE→IDLE cycle.
- No combinational path from `in_valid` or `out_ready` to any output except through registered state.

## Test plan
- **Basic shift.** A = (0xC00000, exp 0x80), B = (0x800000, exp 0x7E) → `swapped` = 0, `common_exponent` = 0x80, `large_mantissa` = 0xC00000, `small_mantissa` = 0x1000000. `out_valid` rises 3 cycles after accept.
- **Swap with round bit.** A = (0x800001, exp 0x7F), B = (0xFFFFFF, exp 0x81) → `swapped` = 1, `large_mantissa` = 0xFFFFFF, `common_exponent` = 0x81, `small_mantissa` = 0x1000002 (G = 0, R = 1, S = 0).
- **Saturating shift.** A = (0xFFFFFF, exp 0xFF), B = (0x800001, exp 0x00) → counter capped at 27, `small_mantissa` = 0x0000001 (sticky only). `out_valid` after 28 cycles.
- **Equal exponents.** A = (0x900000, exp 0x40), B = (0xA00000, exp 0x40) → `swapped` = 0, `small_mantissa` = 0x5000000. `out_valid` 1 cycle after accept.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles in DONE while driving new `in_valid` → outputs unchanged, `in_ready` = 0, new pair not accepted. Raise `out_ready` → IDLE next cycle, `in_ready` = 1.
- **Reset mid-shift.** Start a pair with d = 20, assert `rst` at shift 10 → `in_ready` = 1 and `out_valid` = 0 immediately, all outputs 0. After release, a fresh pair aligns correctly.
